adsr_envelope: RTL and testbench

- Per-voice amplitude envelope stage directly upstream of the two-input signed sample mixer.
- Takes the raw signed oscillator sample stream and scales it by an ADSR envelope level (attack/decay/sustain/release) driven by note_on/note_off events.
- Emits a shaped signed sample of the same width, ready to be one operand of the mixer.

---
 rtl/synth_pkg.sv | 21 ++
 rtl/env_scale.sv | 45 ++++
 rtl/adsr_envelope.sv | 110 +++++++++++
 tb/tb_adsr_envelope.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice blocks: envelope state encodings and level limits.
package synth_pkg;

  localparam int unsigned ENV_W_DEFAULT = 8;
  localparam int unsigned ENV_MAX       = (1 << ENV_W_DEFAULT) - 1;
  localparam int unsigned STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  // True for the states in which a note is still held.
  function automatic logic is_held(input env_state_e st);
    return (st == ST_ATTACK) || (st == ST_DECAY) || (st == ST_SUSTAIN);
  endfunction

endpackage

// File: rtl/env_scale.sv
// Registered signed-sample by unsigned-level multiply, scaled back by 2^ENV_W, with valid pipelining.
module env_scale #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ENV_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] sample_i,
  input  logic        [ENV_W-1:0] level_i,
  output logic signed [WIDTH-1:0] sample_o,
  output logic                    valid_o
);

  localparam int unsigned PROD_W = WIDTH + ENV_W + 1;

  logic signed [PROD_W-1:0] sample_x;
  logic signed [PROD_W-1:0] level_x;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] scaled;
  logic signed [WIDTH-1:0]  sample_q;
  logic                     valid_q;

  // Level is zero-extended so it always acts as a non-negative multiplier.
  assign sample_x = PROD_W'(sample_i);
  assign level_x  = PROD_W'({1'b0, level_i});
  assign product  = sample_x * level_x;
  assign scaled   = product >>> ENV_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        sample_q <= WIDTH'(scaled);
      end
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: event-driven FSM and level register feeding the sample scaler.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ENV_W = ENV_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    note_on,
  input  logic                    note_off,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic        [ENV_W-1:0] attack_step,
  input  logic        [ENV_W-1:0] decay_step,
  input  logic        [ENV_W-1:0] sustain_level,
  input  logic        [ENV_W-1:0] release_step,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    out_valid,
  output logic        [ENV_W-1:0] env_level,
  output logic        [2:0]       env_state,
  output logic                    busy
);

  localparam logic [ENV_W:0] LEVEL_MAX_X = {1'b0, {ENV_W{1'b1}}};

  env_state_e       state_q, state_d;
  logic [ENV_W-1:0] level_q, level_d;
  logic             busy_q, busy_d;

  logic             release_evt;
  logic             event_c;
  logic             tick;
  logic [ENV_W:0]   attack_sum;
  logic [ENV_W:0]   decay_floor;
  logic [ENV_W:0]   level_x;

  // An ignored note_off (IDLE/RELEASE) is not an event and does not block the tick.
  assign release_evt = note_off && is_held(state_q);
  assign event_c     = note_on || release_evt;
  assign tick        = sample_valid && !event_c;

  assign level_x     = {1'b0, level_q};
  assign attack_sum  = level_x + {1'b0, attack_step};
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (note_on) begin
      state_d = ST_ATTACK;
    end else if (release_evt) begin
      state_d = ST_RELEASE;
    end else if (tick) begin
      unique case (state_q)
        ST_ATTACK:  if (attack_sum >= LEVEL_MAX_X) state_d = ST_DECAY;
        ST_DECAY:   if (level_x <= decay_floor) state_d = ST_SUSTAIN;
        ST_RELEASE: if (level_q <= release_step) state_d = ST_IDLE;
        default:    state_d = state_q;
      endcase
    end
  end

  // Level steps only on a tick; event cycles leave the level untouched.
  always_comb begin
    level_d = level_q;
    busy_d  = (state_d != ST_IDLE);
    if (tick) begin
      unique case (state_q)
        ST_IDLE:    level_d = '0;
        ST_ATTACK:  level_d = (attack_sum >= LEVEL_MAX_X) ? LEVEL_MAX_X[ENV_W-1:0]
                                                          : attack_sum[ENV_W-1:0];
        ST_DECAY:   level_d = (level_x <= decay_floor) ? sustain_level
                                                       : level_q - decay_step;
        ST_SUSTAIN: level_d = level_q;
        ST_RELEASE: level_d = (level_q <= release_step) ? '0 : level_q - release_step;
        default:    level_d = level_q;
      endcase
    end
  end

  env_scale #(
    .WIDTH(WIDTH),
    .ENV_W(ENV_W)
  ) u_scale (
    .clk     (clk),
    .reset   (reset),
    .valid_i (sample_valid),
    .sample_i(sample_in),
    .level_i (level_q),
    .sample_o(sample_out),
    .valid_o (out_valid)
  );

  assign env_level = level_q;
  assign env_state = 3'(state_q);
  assign busy      = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed vector bench for adsr_envelope: table of per-cycle stimulus/expectations plus a release sweep.
module tb_adsr_envelope;

  logic               clk = 1'b0;
  logic               reset;
  logic               note_on;
  logic               note_off;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  logic [7:0]         attack_step;
  logic [7:0]         decay_step;
  logic [7:0]         sustain_level;
  logic [7:0]         release_step;
  logic signed [15:0] sample_out;
  logic               out_valid;
  logic [7:0]         env_level;
  logic [2:0]         env_state;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adsr_envelope #(.WIDTH(16), .ENV_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .note_on      (note_on),
    .note_off     (note_off),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .env_level    (env_level),
    .env_state    (env_state),
    .busy         (busy)
  );

  typedef struct {
    logic rst, on, off, sv;
    int   sin, a, d, s, r;
    int   lvl, st, bsy, ov, so;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, on, off, sv, input int sin, a, d, s, r,
                              input int lvl, st, bsy, ov, so);
    vec_t v;
    v.rst = rst; v.on = on; v.off = off; v.sv = sv;
    v.sin = sin; v.a = a; v.d = d; v.s = s; v.r = r;
    v.lvl = lvl; v.st = st; v.bsy = bsy; v.ov = ov; v.so = so;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input int lvl, st, bsy, ov, so);
    check("env_level",  idx, int'(env_level),  lvl);
    check("env_state",  idx, int'(env_state),  st);
    check("busy",       idx, int'(busy),       bsy);
    check("out_valid",  idx, int'(out_valid),  ov);
    check("sample_out", idx, int'(sample_out), so);
  endtask

  task automatic drive(input logic rst, on, off, sv, input int sin, a, d, s, r);
    reset         = rst;
    note_on       = on;
    note_off      = off;
    sample_valid  = sv;
    sample_in     = 16'(sin);
    attack_step   = 8'(a);
    decay_step    = 8'(d);
    sustain_level = 8'(s);
    release_step  = 8'(r);
  endtask

  initial begin
    int ticks;

    // rst on off sv  sin     a   d   s    r  | lvl st bsy ov so
    vecs.push_back(mk(1, 1, 0, 0,      0,  64, 32, 160, 100,   0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 1, 0, 1,   1000,  64, 32, 160, 100,   0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 1, 0, 0,      0,  64, 32, 160, 100,   0, 1, 1, 0,      0));
    vecs.push_back(mk(0, 0, 0, 1,  16384,  64, 32, 160, 100,  64, 1, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,  16384,  64, 32, 160, 100, 128, 1, 1, 1,   4096));
    vecs.push_back(mk(0, 0, 0, 1,  16384,  64, 32, 160, 100, 192, 1, 1, 1,   8192));
    vecs.push_back(mk(0, 0, 0, 1, -16384,  64, 32, 160, 100, 255, 2, 1, 1, -12288));
    vecs.push_back(mk(0, 0, 0, 1, -16384,  64, 32, 160, 100, 223, 2, 1, 1, -16320));
    vecs.push_back(mk(0, 0, 0, 0,      0,  64, 32, 160, 100, 223, 2, 1, 0, -16320));
    vecs.push_back(mk(0, 0, 0, 1,    100,  64, 32, 160, 100, 191, 2, 1, 1,     87));
    vecs.push_back(mk(0, 0, 0, 1,   -100,  64, 32, 160, 100, 160, 3, 1, 1,    -75));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32,  50, 100, 160, 3, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100, 160, 3, 1, 1,      0));
    vecs.push_back(mk(0, 0, 1, 1,    256,  64, 32, 160, 100, 160, 4, 1, 1,    160));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100,  60, 4, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100,   0, 0, 0, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,  12345,  64, 32, 160, 100,   0, 0, 0, 1,      0));
    vecs.push_back(mk(0, 1, 0, 0,      0,  64, 32, 160, 100,   0, 1, 1, 0,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100,  64, 1, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100, 128, 1, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100, 192, 1, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100, 255, 2, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100, 223, 2, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100, 191, 2, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100, 160, 3, 1, 1,      0));
    vecs.push_back(mk(0, 0, 1, 0,      0,  64, 32, 160, 100, 160, 4, 1, 0,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0,  64, 32, 160, 100,  60, 4, 1, 1,      0));
    vecs.push_back(mk(0, 1, 0, 0,      0, 100, 32, 160, 100,  60, 1, 1, 0,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0, 100, 32, 160, 100, 160, 1, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      0, 100, 32, 160, 100, 255, 2, 1, 1,      0));
    vecs.push_back(mk(0, 1, 1, 0,      0, 100, 32, 160, 100, 255, 1, 1, 0,      0));
    vecs.push_back(mk(0, 0, 0, 1,   1000, 100, 32, 160, 100, 255, 2, 1, 1,    996));
    vecs.push_back(mk(1, 0, 0, 1,   5000, 100, 32, 160, 100,   0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 1, 0, 0,      0,   1, 32, 160, 100,   0, 1, 1, 0,      0));
    vecs.push_back(mk(0, 0, 0, 1,     -1,   1, 32, 160, 100,   1, 1, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,     -1,   1, 32, 160, 100,   2, 1, 1, 1,     -1));
    vecs.push_back(mk(0, 0, 0, 1,      7,   0, 32, 160, 100,   2, 1, 1, 1,      0));
    vecs.push_back(mk(0, 0, 0, 1,      7,   0, 32, 160, 100,   2, 1, 1, 1,      0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].on, vecs[i].off, vecs[i].sv,
            vecs[i].sin, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].r);
      @(posedge clk);
      #1;
      check_outputs(i, vecs[i].lvl, vecs[i].st, vecs[i].bsy, vecs[i].ov, vecs[i].so);
    end

    // Saturating attack from level 2, then decay entry already at sustain snaps straight to SUSTAIN.
    drive(0, 0, 0, 1, 0, 255, 10, 160, 1);
    @(posedge clk); #1;
    check_outputs(100, 255, 2, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 255, 10, 255, 1);
    @(posedge clk); #1;
    check_outputs(101, 255, 3, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 255, 10, 255, 1);
    @(posedge clk); #1;
    check_outputs(102, 255, 4, 1, 0, 0);

    // Release with step 1 from 255 must take exactly 255 ticks to reach IDLE.
    ticks = 0;
    drive(0, 0, 0, 1, 0, 255, 10, 255, 1);
    while (busy && ticks < 300) begin
      @(posedge clk); #1;
      ticks++;
    end
    check("release_ticks", 103, ticks, 255);
    check("idle_level", 103, int'(env_level), 0);
    check("idle_state", 103, int'(env_state), 0);

    // A note_off in IDLE is ignored.
    drive(0, 0, 1, 0, 0, 255, 10, 255, 1);
    @(posedge clk); #1;
    check_outputs(104, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
